// File: rtl/if_id_skid_buffer.sv
// IF/ID two-entry skid buffer: holds {PC, PC+4, instruction} between fetch and decode,
// with branch flush and a saturating fetch back-pressure counter.
module if_id_skid_buffer #(
  parameter int                 INSTR_W   = 32,
  parameter int                 ADDR_W    = 64,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F,
  parameter int                 CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  in_pc,
  input  logic [ADDR_W-1:0]  in_pc_plus4,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_pc_plus4,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CNT_W-1:0]   stall_count
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  main_pc_q, main_pc4_q, skid_pc_q, skid_pc4_q;
  logic [INSTR_W-1:0] main_instr_q, skid_instr_q;
  logic [CNT_W-1:0]   stall_q;

  logic accept, pop;
  logic ld_main_in, ld_main_skid, ld_skid;

  assign accept = in_valid & in_ready & ~flush;
  assign pop    = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush overrides every transition; payload loads under flush are harmless
  // because the cleared state gates the outputs.
  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d    = ONE;
          ld_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && pop) begin
          ld_main_in = 1'b1;
        end else if (accept) begin
          state_d = TWO;
          ld_skid = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d      = ONE;
          ld_main_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_comb begin
    in_ready     = (state_q != TWO);
    out_valid    = (state_q != EMPTY);
    out_pc       = main_pc_q;
    out_pc_plus4 = main_pc4_q;
    out_instr    = out_valid ? main_instr_q : NOP_INSTR;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_pc_q    <= '0;
      main_pc4_q   <= '0;
      main_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_pc4_q   <= '0;
      skid_instr_q <= '0;
    end else begin
      if (ld_main_in) begin
        main_pc_q    <= in_pc;
        main_pc4_q   <= in_pc_plus4;
        main_instr_q <= in_instr;
      end else if (ld_main_skid) begin
        main_pc_q    <= skid_pc_q;
        main_pc4_q   <= skid_pc4_q;
        main_instr_q <= skid_instr_q;
      end
      if (ld_skid) begin
        skid_pc_q    <= in_pc;
        skid_pc4_q   <= in_pc_plus4;
        skid_instr_q <= in_instr;
      end
    end
  end

  // Back-pressure counter saturates at all-ones; flush does not touch it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (in_valid && !in_ready && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign stall_count = stall_q;

endmodule

// File: tb/tb_if_id_skid_buffer.sv
// Bench for if_id_skid_buffer: queue scoreboard of accepted entries, per-scenario tasks.
module tb_if_id_skid_buffer;

  localparam int                 IW  = 32;
  localparam int                 AW  = 64;
  localparam int                 CW  = 4;
  localparam logic [IW-1:0]      NOP = 32'hD503201F;
  localparam logic [CW-1:0]      SAT = 4'd15;

  typedef logic [2*AW+IW-1:0] entry_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_pc;
  logic [AW-1:0] in_pc_plus4;
  logic [IW-1:0] in_instr;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_pc;
  logic [AW-1:0] out_pc_plus4;
  logic [IW-1:0] out_instr;
  logic [CW-1:0] stall_count;

  int checks = 0;
  int errors = 0;
  entry_t        sb[$];
  logic [CW-1:0] mdl_stall;

  if_id_skid_buffer #(
    .INSTR_W(IW), .ADDR_W(AW), .NOP_INSTR(NOP), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_pc_plus4(in_pc_plus4), .in_instr(in_instr),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .out_instr(out_instr),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [IW-1:0] instr_of(input logic [AW-1:0] pc);
    return 32'h1100_0000 + pc[31:0];
  endfunction

  // One cycle: drive at negedge, check handshake/scoreboard just after, then cross one posedge.
  task automatic drive(input logic iv, input logic [AW-1:0] pc, input logic ordy, input logic fl);
    logic   exp_v, exp_r;
    entry_t got;
    in_valid    = iv;
    in_pc       = pc;
    in_pc_plus4 = pc + 64'd4;
    in_instr    = instr_of(pc);
    out_ready   = ordy;
    flush       = fl;
    #1;
    exp_v = (sb.size() > 0);
    exp_r = (sb.size() < 2);
    checks++;
    if (out_valid !== exp_v) begin
      errors++;
      $display("FAIL out_valid actual=%0b expected=%0b", out_valid, exp_v);
    end
    checks++;
    if (in_ready !== exp_r) begin
      errors++;
      $display("FAIL in_ready actual=%0b expected=%0b", in_ready, exp_r);
    end
    if (exp_v && ordy) begin
      got = {out_pc, out_pc_plus4, out_instr};
      checks++;
      if (got !== sb[0]) begin
        errors++;
        $display("FAIL pop_entry actual=%0h expected=%0h", got, sb[0]);
      end
      void'(sb.pop_front());
    end
    if (iv && !exp_r && mdl_stall != SAT) mdl_stall = mdl_stall + 4'd1;
    if (fl) sb.delete();
    else if (iv && exp_r) sb.push_back({pc, pc + 64'd4, instr_of(pc)});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_pc = '0; in_pc_plus4 = '0; in_instr = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid actual=%0b expected=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready actual=%0b expected=1", in_ready); end
    checks++; if (out_pc !== 64'd0) begin errors++; $display("FAIL rst_out_pc actual=%0h expected=0", out_pc); end
    checks++; if (out_pc_plus4 !== 64'd0) begin errors++; $display("FAIL rst_out_pc4 actual=%0h expected=0", out_pc_plus4); end
    checks++; if (out_instr !== NOP) begin errors++; $display("FAIL rst_out_instr actual=%0h expected=%0h", out_instr, NOP); end
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL rst_stall actual=%0d expected=0", stall_count); end
    sb.delete();
    mdl_stall = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_stream();
    drive(1'b1, 64'h0, 1'b1, 1'b0);
    #1;
    checks++; if (out_pc !== 64'h0 || out_valid !== 1'b1) begin errors++; $display("FAIL stream_first actual=%0h/%0b expected=0/1", out_pc, out_valid); end
    drive(1'b1, 64'h4, 1'b1, 1'b0);
    #1;
    checks++; if (out_pc !== 64'h4 || out_pc_plus4 !== 64'h8) begin errors++; $display("FAIL stream_second actual=%0h/%0h expected=4/8", out_pc, out_pc_plus4); end
    drive(1'b1, 64'h8, 1'b1, 1'b0);
    #1;
    checks++; if (out_pc !== 64'h8) begin errors++; $display("FAIL stream_third actual=%0h expected=8", out_pc); end
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    drive(1'b0, 64'h0, 1'b1, 1'b0);
  endtask

  task automatic test_skid();
    drive(1'b1, 64'h10, 1'b0, 1'b0);
    drive(1'b1, 64'h14, 1'b0, 1'b0);
    #1;
    checks++; if (in_ready !== 1'b0 || out_pc !== 64'h10) begin errors++; $display("FAIL skid_full actual=%0b/%0h expected=0/10", in_ready, out_pc); end
    drive(1'b1, 64'h18, 1'b0, 1'b0);
    drive(1'b1, 64'h18, 1'b0, 1'b0);
    #1;
    checks++; if (stall_count !== 4'd2) begin errors++; $display("FAIL skid_stall actual=%0d expected=2", stall_count); end
    drive(1'b1, 64'h18, 1'b1, 1'b0);
    drive(1'b1, 64'h18, 1'b1, 1'b0);
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    #1;
    checks++; if (out_valid !== 1'b0 || stall_count !== mdl_stall) begin errors++; $display("FAIL skid_drain actual=%0b/%0d expected=0/%0d", out_valid, stall_count, mdl_stall); end
  endtask

  task automatic test_flush_two();
    drive(1'b1, 64'h20, 1'b0, 1'b0);
    drive(1'b1, 64'h24, 1'b0, 1'b0);
    drive(1'b1, 64'h40, 1'b0, 1'b1);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid actual=%0b expected=0", out_valid); end
    checks++; if (out_instr !== NOP) begin errors++; $display("FAIL flush_instr actual=%0h expected=%0h", out_instr, NOP); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready actual=%0b expected=1", in_ready); end
    drive(1'b1, 64'h80, 1'b0, 1'b0);
    #1;
    checks++; if (out_pc !== 64'h80) begin errors++; $display("FAIL flush_next actual=%0h expected=80", out_pc); end
    drive(1'b0, 64'h0, 1'b1, 1'b0);
  endtask

  task automatic test_pop_flush();
    drive(1'b1, 64'h100, 1'b0, 1'b0);
    drive(1'b0, 64'h0, 1'b1, 1'b1);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL popflush_valid actual=%0b expected=0", out_valid); end
    drive(1'b0, 64'h0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    drive(1'b1, 64'h200, 1'b0, 1'b0);
    drive(1'b1, 64'h204, 1'b0, 1'b0);
    drive(1'b1, 64'h208, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid actual=%0b expected=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_ready actual=%0b expected=1", in_ready); end
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL arst_stall actual=%0d expected=0", stall_count); end
    checks++; if (out_instr !== NOP) begin errors++; $display("FAIL arst_instr actual=%0h expected=%0h", out_instr, NOP); end
    sb.delete();
    mdl_stall = '0;
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 64'h300, 1'b0, 1'b0);
    #1;
    checks++; if (out_pc !== 64'h300) begin errors++; $display("FAIL arst_first actual=%0h expected=300", out_pc); end
    drive(1'b0, 64'h0, 1'b1, 1'b0);
  endtask

  task automatic test_saturation();
    drive(1'b1, 64'h400, 1'b0, 1'b0);
    drive(1'b1, 64'h404, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b1, 64'h408, 1'b0, 1'b0);
    #1;
    checks++; if (stall_count !== SAT) begin errors++; $display("FAIL sat_count actual=%0d expected=15", stall_count); end
    drive(1'b1, 64'h408, 1'b1, 1'b0);
    drive(1'b1, 64'h40C, 1'b1, 1'b0);
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    #1;
    checks++; if (stall_count !== SAT || out_valid !== 1'b0) begin errors++; $display("FAIL sat_hold actual=%0d/%0b expected=15/0", stall_count, out_valid); end
  endtask

  initial begin
    mdl_stall = '0;
    test_reset();
    @(negedge clk);
    test_stream();
    test_skid();
    test_flush_two();
    test_pop_flush();
    test_async_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
